// File: rtl/tx_byte_pacer_pkg.sv
// Shared state encoding, default timing constants and sizing helpers for the
// tx_byte_pacer slice.
package tx_byte_pacer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_GAP    = 2'd3
    } pacer_state_t;

    localparam int DEF_DEPTH         = 8;
    localparam int DEF_SETUP_CYCLES  = 4;
    localparam int DEF_STROBE_CYCLES = 4;
    localparam int DEF_GAP_CYCLES    = 1024;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // One counter serves every phase, so it is sized for the longest one.
    function automatic int cnt_width(input int s, input int t, input int g);
        return $clog2(max3(s, t, g)) + 1;
    endfunction

endpackage

// File: rtl/tx_byte_fifo.sv
// Single-clock byte FIFO; head is always visible on rd_data, no write bypass.
module tx_byte_fifo #(
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk_dot4x,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    // Flags come only from the registered level, never from wr_en/rd_en.
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk_dot4x or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk_dot4x) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/tx_byte_pacer.sv
// Queues bytes and presents them to a slow-domain transmitter with a stable
// data/strobe framing: setup, multi-cycle strobe, then a long idle gap.
module tx_byte_pacer
    import tx_byte_pacer_pkg::*;
#(
    parameter int DEPTH         = DEF_DEPTH,
    parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
    parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
    parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
    localparam int LW = $clog2(DEPTH) + 1,
    localparam int CW = cnt_width(SETUP_CYCLES, STROBE_CYCLES, GAP_CYCLES)
) (
    input  logic          clk_dot4x,
    input  logic          rst,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [7:0]    tx_data_4x,
    output logic          tx_new_data_4x,
    output logic          busy,
    output logic [LW-1:0] level,
    output pacer_state_t  fsm_state
);

    pacer_state_t state;
    pacer_state_t state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [7:0]    data_nxt;
    logic          strobe_nxt;
    logic          pop;
    logic [7:0]    fifo_head;
    logic          fifo_full;
    logic          fifo_empty;

    // Handshake: a byte is pushed on any edge where in_valid && in_ready.
    tx_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_dot4x (clk_dot4x),
        .rst       (rst),
        .wr_en     (in_valid),
        .wr_data   (in_data),
        .rd_en     (pop),
        .rd_data   (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    assign in_ready  = !fifo_full;
    assign busy      = (state != ST_IDLE) || !fifo_empty;
    assign fsm_state = state;

    always_ff @(posedge clk_dot4x or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            tx_data_4x     <= 8'h00;
            tx_new_data_4x <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            tx_data_4x     <= data_nxt;
            tx_new_data_4x <= strobe_nxt;
        end
    end

    // tx_data_4x is only ever reloaded on the IDLE pop, so it is stable for
    // the whole setup/strobe/gap window seen by the slow-domain flops.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        data_nxt   = tx_data_4x;
        strobe_nxt = tx_new_data_4x;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    data_nxt  = fifo_head;
                    cnt_nxt   = CW'(SETUP_CYCLES - 1);
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt == '0) begin
                    strobe_nxt = 1'b1;
                    cnt_nxt    = CW'(STROBE_CYCLES - 1);
                    state_nxt  = ST_STROBE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            ST_STROBE: begin
                if (cnt == '0) begin
                    strobe_nxt = 1'b0;
                    cnt_nxt    = CW'(GAP_CYCLES - 1);
                    state_nxt  = ST_GAP;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt  = ST_IDLE;
                strobe_nxt = 1'b0;
            end
        endcase
    end

endmodule
